apb_master_bridge_mc: RTL
=========================

Name: apb_master_bridge_mc

Overview:
- Parametrised multi-slave APB4 master bridge; successor to the fixed 9-bit-address, 8-bit-data, two-slave APB master.
- Converts the user-side command port (transfer / READ_WRITE / address / data) into APB SETUP/ACCESS cycles.
- Decodes the slave select from the upper address bits and supports wait states, byte strobes, back-to-back transfers and an ACCESS-phase timeout.
- Sits between the test sequencer/driver side and NUM_SLV APB slaves.

Parameters:
ADDR_W, 9, user/APB address width; must be > SEL_W
DATA_W, 8, data width; multiple of 8
NUM_SLV, 2, number of slaves (1..16); SEL_W = max(1, clog2(NUM_SLV)) localparam
TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 = no timeout

Ports:
PCLK  in  1  clock, rising edge
PRESETn  in  1  asynchronous active-low reset
transfer  in  1  command request; sampled in IDLE or at ACCESS completion
READ_WRITE  in  1  1 = write, 0 = read
apb_write_paddr  in  ADDR_W  write address
apb_write_data  in  DATA_W  write data
apb_write_strb  in  DATA_W/8  write byte strobes
apb_read_paddr  in  ADDR_W  read address
apb_read_data_out  out  DATA_W  last read data, held
PSLVERR  out  1  error status of last completed transfer, held
done  out  1  one-cycle completion pulse
busy  out  1  high when state != IDLE
PSEL  out  NUM_SLV  one-hot slave select
PENABLE  out  1  ACCESS phase
PWRITE  out  1  direction
PADDR  out  ADDR_W  captured address
PWDATA  out  DATA_W  captured write data
PSTRB  out  DATA_W/8  write strobes; 0 on reads
PRDATA  in  NUM_SLV*DATA_W  slave read data, slave i at bits [i*DATA_W +: DATA_W]
PREADY  in  NUM_SLV  per-slave ready
PSLVERR_S  in  NUM_SLV  per-slave error

Behaviour:
- Reset (asynchronous, immediate, also mid-transfer): state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, apb_read_data_out=0, PSLVERR=0, done=0, busy=0, timeout counter 0. No completion is reported for an aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - transfer=1 at a clock edge captures PWRITE=READ_WRITE.
  - PADDR = write addr if write, else read addr.
  - PWDATA and PSTRB are captured on writes; on reads PWDATA holds its previous value and PSTRB=0.
  - Go to SETUP.
- Slave decode: idx = PADDR[ADDR_W-1 -: SEL_W].
  - idx < NUM_SLV: PSEL[idx]=1 in SETUP/ACCESS.
  - idx >= NUM_SLV: PSEL stays 0; SETUP goes directly to completion with PSLVERR=1, read data 0, no ACCESS phase.
- SETUP: PENABLE=0; unconditionally to ACCESS on the next edge.
- ACCESS: PENABLE=1; address, control and data stable.
  - PREADY[idx]=1: complete.
  - Else the counter increments each cycle. When it reaches TIMEOUT (TIMEOUT != 0), complete with error.
- Completion edge:
  - done=1 for exactly one cycle.
  - PSLVERR = PSLVERR_S[idx], or 1 on timeout/decode error.
  - Read: apb_read_data_out = PRDATA slice idx, or 0 if errored.
  - Write: apb_read_data_out is unchanged.
  - Counter cleared.
- Back-to-back: transfer=1 on the completion edge captures a new command and goes directly to SETUP; PSEL drops for no cycle if the same slave is selected. Otherwise go to IDLE with PSEL=0 and PENABLE=0.
- Latency: transfer sampled at edge k → SETUP during k..k+1, ACCESS from k+1. With zero wait states, done is high in cycle k+2..k+3. Each wait state adds one cycle.
- transfer and address/data changes during SETUP/ACCESS are ignored; they are not queued.
- PSLVERR and apb_read_data_out only change at completion or reset.
- PREADY/PSLVERR_S/PRDATA of non-selected slaves are ignored. PSLVERR_S is ignored unless PREADY is high.

Test Plan:
- Reset check: PRESETn=0 while ACCESS is waiting → PSEL=0, PENABLE=0, apb_read_data_out=0, PSLVERR=0 immediately, no done. After release, state is IDLE.
- Zero-wait write: addr 9'h005, data 8'hA5, strb 1, slave 0 → PSEL=2'b01.
  - Cycle 1: PENABLE=0. Cycle 2: PENABLE=1 with PREADY=1.
  - done on the 3rd cycle, PSLVERR=0.
- Wait-state read: addr 9'h10C (slave 1), PREADY low for 3 cycles, PRDATA[15:8]=8'h3C → done on the 6th cycle, apb_read_data_out=8'h3C, PSTRB=0.
- Slave error read: PSLVERR_S[1]=1 with PREADY → PSLVERR=1, apb_read_data_out=0. Next successful write → PSLVERR=0, read data unchanged.
- Timeout: TIMEOUT=4, PREADY held 0 → completion after 4 ACCESS cycles, PSLVERR=1, PSEL released. Decode error: NUM_SLV=3, ADDR_W=9, addr 9'h1F0 → no PSEL, PSLVERR=1, done after SETUP.
- Back-to-back: transfer held 1 for write 0x005 then read 0x006 → second SETUP in the cycle after the first ACCESS, PSEL continuous, two done pulses 2 cycles apart.

Source files
------------

// File: rtl/apb_master_bridge_mc.sv
// ---------------------------------------------------------------------------
// apb_master_bridge_mc
//
// Parametrised APB4 master bridge serving NUM_SLV slaves. A command on the
// user side (transfer / READ_WRITE / address / data) is turned into an APB
// SETUP phase followed by one or more ACCESS cycles. The slave is chosen
// from the top SEL_W address bits; an address that decodes to no slave
// finishes straight after SETUP with an error. An ACCESS phase that waits
// TIMEOUT cycles without PREADY is aborted with an error (TIMEOUT = 0
// disables the abort). A new command offered on the completion edge starts
// the next SETUP immediately.
//
// Ports:
//   PCLK, PRESETn       clock (rising edge), asynchronous active-low reset
//   transfer            command request, sampled in IDLE or on completion
//   READ_WRITE          1 = write, 0 = read
//   apb_write_paddr     write address
//   apb_write_data      write data
//   apb_write_strb      write byte strobes
//   apb_read_paddr      read address
//   apb_read_data_out   data of the last completed read, held
//   PSLVERR             error status of the last completed transfer, held
//   done                one-cycle completion pulse
//   busy                high whenever a transfer is in SETUP or ACCESS
//   PSEL                one-hot slave select
//   PENABLE             ACCESS phase indicator
//   PWRITE, PADDR       captured direction and address
//   PWDATA, PSTRB       captured write data and strobes (PSTRB = 0 on reads)
//   PRDATA              concatenated slave read data, slave i at [i*DATA_W +: DATA_W]
//   PREADY, PSLVERR_S   per-slave ready and error
// ---------------------------------------------------------------------------
module apb_master_bridge_mc #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 8,
   parameter int NUM_SLV = 2,
   parameter int TIMEOUT = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESETn,
   input  logic                      transfer,
   input  logic                      READ_WRITE,
   input  logic [ADDR_W-1:0]         apb_write_paddr,
   input  logic [DATA_W-1:0]         apb_write_data,
   input  logic [DATA_W/8-1:0]       apb_write_strb,
   input  logic [ADDR_W-1:0]         apb_read_paddr,
   output logic [DATA_W-1:0]         apb_read_data_out,
   output logic                      PSLVERR,
   output logic                      done,
   output logic                      busy,
   output logic [NUM_SLV-1:0]        PSEL,
   output logic                      PENABLE,
   output logic                      PWRITE,
   output logic [ADDR_W-1:0]         PADDR,
   output logic [DATA_W-1:0]         PWDATA,
   output logic [DATA_W/8-1:0]       PSTRB,
   input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
   input  logic [NUM_SLV-1:0]        PREADY,
   input  logic [NUM_SLV-1:0]        PSLVERR_S
);

   localparam int SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t            state;
   state_t            state_next;

   logic [SEL_W-1:0]  sel_idx;
   logic              sel_valid;
   logic              sel_ready;
   logic              sel_err;
   logic [DATA_W-1:0] sel_rdata;
   logic [CNT_W-1:0]  wait_cnt;
   logic              timeout_hit;
   logic              complete;
   logic              fail;
   logic              capture;

   assign sel_idx = PADDR[ADDR_W-1 -: SEL_W];
   assign busy    = (state != IDLE);
   assign PENABLE = (state == ACCESS);

   // When NUM_SLV fills the whole select field every index is a real slave,
   // so the range check is only built when some encodings are unused.
   generate
      if ((1 << SEL_W) == NUM_SLV) begin : g_full_decode
         assign sel_valid = 1'b1;
      end else begin : g_partial_decode
         assign sel_valid = (int'(sel_idx) < NUM_SLV);
      end
   endgenerate

   // The timeout fires on the last permitted wait cycle, so the abort edge
   // is the one ending the TIMEOUT-th ACCESS cycle with PREADY still low.
   generate
      if (TIMEOUT > 0) begin : g_timeout
         assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
      end else begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end
   endgenerate

   // Pick out the addressed slave's ready, error and read data, and drive
   // its select line while a transfer is in flight. An out-of-range index
   // matches no slave, which leaves PSEL all zero for a decode error.
   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      PSEL      = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (sel_idx == SEL_W'(i)) begin
            sel_ready = PREADY[i];
            sel_err   = PSLVERR_S[i];
            sel_rdata = PRDATA[i*DATA_W +: DATA_W];
            PSEL[i]   = (state != IDLE);
         end
      end
   end

   // Next-state logic. A transfer completes either from SETUP (no slave
   // behind the address) or from ACCESS (slave ready or timeout). On the
   // completion edge a pending request is captured and goes straight back
   // to SETUP, which keeps PSEL asserted between back-to-back transfers to
   // the same slave.
   always_comb begin
      state_next = state;
      complete   = 1'b0;
      fail       = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (transfer) begin
               capture    = 1'b1;
               state_next = SETUP;
            end
         end
         SETUP: begin
            if (!sel_valid) begin
               complete = 1'b1;
               fail     = 1'b1;
            end else begin
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            if (sel_ready) begin
               complete = 1'b1;
               fail     = sel_err;
            end else if (timeout_hit) begin
               complete = 1'b1;
               fail     = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (complete) begin
         if (transfer) begin
            capture    = 1'b1;
            state_next = SETUP;
         end else begin
            state_next = IDLE;
         end
      end
   end

   // State register.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Command capture. Reads keep the previous PWDATA and force the strobes
   // to zero; the address comes from whichever port matches the direction.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PWRITE <= 1'b0;
         PADDR  <= '0;
         PWDATA <= '0;
         PSTRB  <= '0;
      end else if (capture) begin
         PWRITE <= READ_WRITE;
         if (READ_WRITE) begin
            PADDR  <= apb_write_paddr;
            PWDATA <= apb_write_data;
            PSTRB  <= apb_write_strb;
         end else begin
            PADDR  <= apb_read_paddr;
            PSTRB  <= {STRB_W{1'b0}};
         end
      end
   end

   // Completion reporting. The status and read data only move on a
   // completion edge; a failed read returns zero and a write never
   // disturbs the last read data.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         done              <= 1'b0;
         PSLVERR           <= 1'b0;
         apb_read_data_out <= '0;
      end else begin
         done <= complete;
         if (complete) begin
            PSLVERR <= fail;
            if (!PWRITE) begin
               apb_read_data_out <= fail ? '0 : sel_rdata;
            end
         end
      end
   end

   // Wait-state counter: counts ACCESS cycles that end without PREADY and
   // clears whenever the transfer completes or the bridge leaves ACCESS.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wait_cnt <= '0;
      end else if ((state == ACCESS) && !complete && (TIMEOUT > 0)) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
         wait_cnt <= '0;
      end
   end

endmodule
